// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch sequencer for a combinational 32-bit instruction memory.
// Optional fetch counter under INSTR_COUNT_EN. Rev 1.0
`default_nettype none

module instr_fetch_ctrl #(
  parameter int          ADDR_W     = 10,
  parameter int          DATA_W     = 32,
  parameter int          PROG0_BASE = 1,
  parameter int          PROG1_BASE = 15,
  parameter int          PROG2_BASE = 30,
  parameter int          MEM_LAST   = 80,
  parameter logic [5:0]  HALT_OPC   = 6'b111111
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        prog_sel,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_instr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fault,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED, FAULT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [DATA_W-1:0] instr_nxt;
  logic              valid_nxt;
  logic              fault_nxt;
  logic [ADDR_W-1:0] last_addr;

  assign last_addr   = ADDR_W'(MEM_LAST);
  assign mem_address = pc;
  assign busy        = (state == FETCH);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_valid <= valid_nxt;
      fault       <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    valid_nxt = instr_valid;
    fault_nxt = fault;
    case (state)
      FETCH: begin
        if (halt_req) begin
          state_nxt = HALTED;
          valid_nxt = 1'b0;
        end else if (stall) begin
          // Everything holds; a concurrent redirect must be re-presented later.
          state_nxt = FETCH;
        end else if (redirect_valid) begin
          valid_nxt = 1'b0;
          if (redirect_addr > last_addr) begin
            state_nxt = FAULT;
            fault_nxt = 1'b1;
          end else begin
            pc_nxt = redirect_addr;
          end
        end else begin
          instr_nxt = mem_instr;
          valid_nxt = 1'b1;
          if (mem_instr[DATA_W-1 -: 6] == HALT_OPC) begin
            state_nxt = HALTED;
          end else if (pc == last_addr) begin
            state_nxt = FAULT;
            fault_nxt = 1'b1;
          end else begin
            pc_nxt = pc + ADDR_W'(1);
          end
        end
      end
      default: begin
        valid_nxt = 1'b0;
        if (start) begin
          case (prog_sel)
            2'd0: begin pc_nxt = ADDR_W'(PROG0_BASE); fault_nxt = 1'b0; state_nxt = FETCH; end
            2'd1: begin pc_nxt = ADDR_W'(PROG1_BASE); fault_nxt = 1'b0; state_nxt = FETCH; end
            2'd2: begin pc_nxt = ADDR_W'(PROG2_BASE); fault_nxt = 1'b0; state_nxt = FETCH; end
            default: begin state_nxt = FAULT; fault_nxt = 1'b1; end
          endcase
        end
      end
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic        count_inc;
  logic        count_clr;
  logic [15:0] count_q;

  assign count_inc = (state == FETCH) && !halt_req && !stall && !redirect_valid;
  assign count_clr = (state != FETCH) && start && (prog_sel != 2'd3);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (count_clr) begin
      count_q <= '0;
    end else if (count_inc && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Fetch sequencer for the 10-bit-addressed, 32-bit-wide instruction memory, which is read combinationally.
- Selects one of three resident programs by base address and drives the memory address.
- Latches each fetched word into an instruction register with a valid flag.
- Handles stall, redirect (branch/jump), halt and out-of-range faults; sits between the user program-select inputs and the CPU decode stage.

Parameters:
ADDR_W, 10, instruction memory address width
DATA_W, 32, instruction width
PROG0_BASE, 1, start address of program 0 (fibonacci)
PROG1_BASE, 15, start address of program 1 (fatorial)
PROG2_BASE, 30, start address of program 2 (sintetico)
MEM_LAST, 80, highest valid memory address
HALT_OPC, 6'b111111, opcode (bits 31:26) that ends a program

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin program prog_sel (sampled in IDLE/HALTED/FAULT)
prog_sel  input  2  0/1/2 select program base; 3 is illegal
stall  input  1  decode not ready; hold pc and instr
halt_req  input  1  stop fetching
redirect_valid  input  1  branch/jump taken
redirect_addr  input  ADDR_W  new fetch address
mem_address  output  ADDR_W  to memory address input, equals pc
mem_instr  input  DATA_W  from memory instruction output
instr  output  DATA_W  instruction register
instr_valid  output  1  instr holds a fresh instruction
pc  output  ADDR_W  current fetch address
busy  output  1  state is FETCH
fault  output  1  illegal select or address out of range
fetch_count  output  16  fetched-instruction count (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - pc, mem_address, instr, fetch_count = 0.
  - instr_valid, busy, fault = 0.
- mem_address = pc combinationally; no extra delay.
- States: IDLE, FETCH, HALTED, FAULT.
- IDLE/HALTED/FAULT with start=1:
  - prog_sel 0/1/2: pc<=base, fault<=0, instr_valid<=0, go to FETCH.
  - prog_sel 3: go to FAULT, fault<=1, pc unchanged.
  - start=0: stay; outputs hold, instr_valid=0.
- FETCH, per-cycle priority: halt_req > stall > redirect_valid > advance.
  - halt_req: go to HALTED, instr_valid<=0, pc holds.
  - stall: pc, instr and instr_valid all hold; a concurrent redirect is ignored, so the requester must hold it until stall drops.
  - redirect_valid:
    - redirect_addr>MEM_LAST: go to FAULT, fault<=1, instr_valid<=0.
    - otherwise pc<=redirect_addr, instr_valid<=0 (one bubble); the word at the old pc is discarded.
  - advance:
    - instr<=mem_instr, instr_valid<=1.
    - if mem_instr[31:26]==HALT_OPC: go to HALTED, pc holds; the halt word is still presented valid for that one cycle.
    - else if pc==MEM_LAST: go to FAULT, fault<=1; the last word is still presented valid.
    - else pc<=pc+1.
- Latency: start sampled at edge N, pc=base after N. RAM[base] appears on instr with instr_valid=1 after edge N+1; one instruction per unstalled cycle thereafter.
- busy=1 exactly while state==FETCH.
- start while in FETCH is ignored.
- Reset mid-fetch: immediate return to reset values; no partial state survives.
- The memory initialises its contents on its first clock edge. The earliest fetch happens at least 2 cycles after reset release, so no special handling is required.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- Defined:
  - fetch_count increments on every advance with instr_valid<=1.
  - Cleared to 0 on a legal start; saturates at 16'hFFFF.
  - Holds through stall, HALTED and FAULT.
- Undefined: fetch_count is tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset, prog_sel=0, start pulse -> pc=1 next cycle; instr=RAM[1], instr_valid=1 the cycle after; pc increments 1,2,3...; busy=1.
- In FETCH, stall high for 3 cycles at pc=5 -> pc stays 5; instr and instr_valid hold; resumes with RAM[5] after stall drops.
- redirect_valid with redirect_addr=6 at pc=9 -> one cycle instr_valid=0, then instr=RAM[6], pc=7.
- prog_sel=3 with start -> fault=1, state FAULT, busy=0; then start with prog_sel=1 -> fault=0, pc=15.
- redirect_addr=100, or advance at pc=80 -> fault=1, FAULT, no further pc change; halt_req during FETCH -> HALTED, instr_valid=0 next cycle.
- With INSTR_COUNT_EN: start prog 2, 6 unstalled fetches plus 2 stall cycles -> fetch_count=6; reset_n pulse mid-run -> all outputs 0 immediately.
